// File: rtl/divider_result_monitor_pkg.sv
// divider_monitor_pkg
// Shared types and constants for the divider result monitor.
//   - display_state_e : which statistic is shown on the LEDs (2 bits)
//   - MIN_RESET / MAX_RESET : values that any real sample replaces
//   - COUNT_SAT : the accepted-sample counter holds at this value
//   - nextDisplayState : order in which the LEDs cycle through the statistics
// Build option: MONITOR_AVG_EN adds SHOW_AVG to the LED rotation.
package divider_monitor_pkg;

  typedef enum logic [1:0] {
    SHOW_LAST = 2'b00,
    SHOW_MIN  = 2'b01,
    SHOW_MAX  = 2'b10,
    SHOW_AVG  = 2'b11
  } display_state_e;

  // Minimum starts at the most positive value and maximum at the most
  // negative value, so the first sample replaces both.
  localparam logic [7:0] MIN_RESET = 8'h7F;
  localparam logic [7:0] MAX_RESET = 8'h80;
  localparam logic [7:0] COUNT_SAT = 8'd255;

  // Without the averager the rotation skips SHOW_AVG and goes from
  // SHOW_MAX straight back to SHOW_LAST.
  function automatic display_state_e nextDisplayState(input display_state_e s);
    case (s)
      SHOW_LAST: return SHOW_MIN;
      SHOW_MIN:  return SHOW_MAX;
`ifdef MONITOR_AVG_EN
      SHOW_MAX:  return SHOW_AVG;
`endif
      default:   return SHOW_LAST;
    endcase
  endfunction

endpackage

// File: rtl/divider_result_monitor_avg_window.sv
// avg_window
// Moving average over the last 2^AVG_LOG2 accepted samples. It uses a
// circular buffer and a running sum.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_sample         : signed sample (DATA_W bits)
//   i_accept         : strobe; i_sample is taken this cycle
//   i_clear          : synchronous clear; a sample accepted in the same
//                      cycle becomes the first sample of the new window
//   o_avg            : registered average, sum >>> AVG_LOG2 (rounds toward -inf)
// Slots that have not been written yet hold zero and still count in the
// average.
module avg_window
  import divider_monitor_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 3
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_accept,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;

  logic        [DATA_W-1:0]   buf_q [DEPTH];
  logic        [AVG_LOG2-1:0] wrPtr_q;
  logic signed [SUM_W-1:0]    sum_q, sum_d;
  logic signed [SUM_W-1:0]    sampleExt, oldestExt, avgFull;
  logic        [DATA_W-1:0]   avg_q, avg_d;

  // The write pointer always points at the oldest slot. The new sum
  // replaces the oldest value with the incoming one. The average is taken
  // from the next sum, so o_avg has the same one-cycle latency as the
  // other statistics.
  always_comb begin
    sampleExt = {{AVG_LOG2{i_sample[DATA_W-1]}}, i_sample};
    oldestExt = {{AVG_LOG2{buf_q[wrPtr_q][DATA_W-1]}}, buf_q[wrPtr_q]};
    sum_d     = sum_q;
    if (i_clear) begin
      sum_d = i_accept ? sampleExt : '0;
    end else if (i_accept) begin
      sum_d = sum_q - oldestExt + sampleExt;
    end
    avgFull = sum_d >>> AVG_LOG2;
    avg_d   = avgFull[DATA_W-1:0];
  end

  // On clear, every slot is zeroed. A sample accepted in the same cycle
  // goes into slot 0, so it counts as the first sample.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      wrPtr_q <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
    end else begin
      if (i_clear) begin
        for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        if (i_accept) begin
          buf_q[0] <= i_sample;
          wrPtr_q  <= AVG_LOG2'(1);
        end else begin
          wrPtr_q  <= '0;
        end
      end else if (i_accept) begin
        buf_q[wrPtr_q] <= i_sample;
        wrPtr_q        <= wrPtr_q + AVG_LOG2'(1);
      end
      sum_q <= sum_d;
      avg_q <= avg_d;
    end
  end

  assign o_avg = avg_q;

endmodule

// File: rtl/divider_result_monitor.sv
// divider_result_monitor
// Takes the divider's signed Q4.4 quotient stream and keeps these
// statistics: last sample, signed min and max, sample count (holds at 255),
// and, when built, a moving average. A display FSM cycles these values
// onto six LEDs. Each value stays on the LEDs for DISPLAY_TICKS cycles.
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_data, i_valid  : quotient and its valid strobe
//   i_clear          : synchronous clear of the statistics (display unaffected)
//   o_last, o_min, o_max, o_avg, o_count : registered statistics
//   o_led            : {display state, upper nibble of the shown value}
// Build option: MONITOR_AVG_EN builds the averager and the SHOW_AVG slot;
// when it is undefined, o_avg is tied to zero.
module divider_result_monitor
  import divider_monitor_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int AVG_LOG2      = 3,
  parameter int DISPLAY_TICKS = 27_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_last,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max,
  output logic [DATA_W-1:0] o_avg,
  output logic [7:0]        o_count,
  output logic [5:0]        o_led
);

  localparam int TICK_W = (DISPLAY_TICKS > 1) ? $clog2(DISPLAY_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DISPLAY_TICKS - 1);

  logic [DATA_W-1:0] last_q, min_q, max_q, avgVal, selected;
  logic [7:0]        count_q;
  logic [TICK_W-1:0] tick_q;
  logic [5:0]        led_q;
  display_state_e    state_q;

`ifdef MONITOR_AVG_EN
  avg_window #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avgWindow (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_sample  (i_data),
    .i_accept  (i_valid),
    .i_clear   (i_clear),
    .o_avg     (avgVal)
  );
`else
  assign avgVal = '0;
`endif

  // A clear together with a valid makes that sample the first one.
  // A clear alone restores the reset values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_q  <= '0;
      min_q   <= MIN_RESET;
      max_q   <= MAX_RESET;
      count_q <= '0;
    end else if (i_clear) begin
      if (i_valid) begin
        last_q  <= i_data;
        min_q   <= i_data;
        max_q   <= i_data;
        count_q <= 8'd1;
      end else begin
        last_q  <= '0;
        min_q   <= MIN_RESET;
        max_q   <= MAX_RESET;
        count_q <= '0;
      end
    end else if (i_valid) begin
      last_q <= i_data;
      if ($signed(i_data) < $signed(min_q)) min_q <= i_data;
      if ($signed(i_data) > $signed(max_q)) max_q <= i_data;
      if (count_q != COUNT_SAT) count_q <= count_q + 8'd1;
    end
  end

  // Chooses the statistic that goes with the current display state.
  always_comb begin
    selected = last_q;
    case (state_q)
      SHOW_LAST: selected = last_q;
      SHOW_MIN:  selected = min_q;
      SHOW_MAX:  selected = max_q;
      SHOW_AVG:  selected = avgVal;
      default:   selected = last_q;
    endcase
  end

  // The LED pattern is taken from the registered state and statistics, so
  // the LEDs update one cycle after either of them changes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= SHOW_LAST;
      tick_q  <= '0;
      led_q   <= '0;
    end else begin
      if (tick_q == TICK_LAST) begin
        tick_q  <= '0;
        state_q <= nextDisplayState(state_q);
      end else begin
        tick_q  <= tick_q + TICK_W'(1);
      end
      led_q <= {state_q, selected[DATA_W-1 -: 4]};
    end
  end

  assign o_last  = last_q;
  assign o_min   = min_q;
  assign o_max   = max_q;
  assign o_avg   = avgVal;
  assign o_count = count_q;
  assign o_led   = led_q;

endmodule

// File: doc/divider_result_monitor.md
# divider_result_monitor

Downstream consumer of the signed fixed-point long divider's 8-bit quotient stream. Captures each valid quotient and keeps the last sample, a running min and max, and a moving average over a power-of-two window. A display state machine rotates these values onto the six board LEDs at a fixed tick rate. It sits between the divider output and the `o_led` pins of the nano20k top level.

## Interface
- `DATA_W`, 8: quotient width; signed two's complement, Q4.4.
- `AVG_LOG2`, 3: log2 of the moving-average window (window = 8 samples).
- `DISPLAY_TICKS`, 27_000_000: clock cycles per display slot (1 s at 27 MHz).
- `i_clk`  in  1  system clock; the only clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_data`  in  DATA_W  quotient from the divider.
- `i_valid`  in  1  `i_data` is a new quotient this cycle.
- `i_clear`  in  1  synchronous clear of the statistics.
- `o_last`  out  DATA_W  most recent accepted sample.
- `o_min`  out  DATA_W  signed minimum since reset or clear.
- `o_max`  out  DATA_W  signed maximum since reset or clear.
- `o_avg`  out  DATA_W  moving average.
- `o_count`  out  8  accepted-sample count; saturates at 255.
- `o_led`  out  6  `{state[1:0], selected_value[7:4]}`, active-high logic.

## Operation
- Reset values:
  - `o_last` = 0x00, `o_min` = 0x7F, `o_max` = 0x80, `o_avg` = 0x00, `o_count` = 0.
  - Window buffer and running sum are all zero.
  - Display state is SHOW_LAST, tick counter is 0, `o_led` = 6'b000000.
- Sample accept (`i_valid`=1, `i_clear`=0):
  - `o_last` ← `i_data`.
  - `o_min` ← signed min(`o_min`, `i_data`); `o_max` ← signed max(`o_max`, `i_data`).
  - `o_count` increments and saturates at 255.
  - Window write pointer advances modulo 2^AVG_LOG2.
- Moving average:
  - Running sum is DATA_W+AVG_LOG2 bits, signed.
  - Each accepted sample updates sum ← sum − oldest + new, and `i_data` overwrites the oldest slot.
  - `o_avg` = sum >>> AVG_LOG2, arithmetic shift, truncation toward −∞.
  - Until the window fills, the zero-initialised slots count in the average. This is intended.
- Clear (`i_clear`=1) restores all statistics, the buffer, the sum and `o_count` to their reset values. The display state and tick counter are not affected.
- Clear and valid in the same cycle: the clear applies and the sample becomes the first sample.
  - `o_last` = `o_min` = `o_max` = `i_data` and `o_count` = 1.
  - The buffer holds only that sample; the sum equals `i_data`.
- Display FSM: SHOW_LAST(00) → SHOW_MIN(01) → SHOW_MAX(10) → SHOW_AVG(11) → SHOW_LAST.
  - The state advances when the tick counter reaches DISPLAY_TICKS−1; the counter then wraps to 0.
  - `selected_value` is the output that matches the current state.
- Before any sample arrives, SHOW_MIN and SHOW_MAX display the reset constants: upper nibble 0x7 and 0x8 respectively.

## Timing
- All outputs are registered.
- Statistics are visible on the cycle after the `i_valid` edge.
- `o_avg` has a latency of 1 cycle, the same as `o_last`.
- Back-to-back `i_valid` every cycle is supported; there is no backpressure and no ready signal.
- `o_led` updates one cycle after a state change or a statistics change.
- Reset asserted mid-operation forces every output to its reset value immediately, without waiting for a clock edge.

## Configuration
- `MONITOR_AVG_EN` defined:
  - Window buffer, running sum and `o_avg` are built.
  - The FSM uses all four states.
- `MONITOR_AVG_EN` undefined:
  - No buffer and no sum are built; `o_avg` is tied to 0.
  - The FSM rotates through three states: SHOW_LAST → SHOW_MIN → SHOW_MAX → SHOW_LAST.

## Structure
- Package `divider_monitor_pkg` holds:
  - the display-state enum (2 bits);
  - reset constants for min (0x7F) and max (0x80);
  - the saturation limit for `o_count` (255).
- Sub-module `avg_window` contains:
  - the circular buffer, the write pointer, the running sum and the arithmetic shift;
  - inputs: sample, accept strobe, clear;
  - output: the average.
- The top of the block holds min/max/last/count, the tick counter and the FSM.

## Test plan
- Reset, then samples 0x10, 0xF0, 0x30 on consecutive cycles → `o_last`=0x30, `o_min`=0xF0, `o_max`=0x30, `o_count`=3, `o_avg`=(0x10−0x10+0x30)>>>3 = 0x06.
- Eight samples of 0xE0 → `o_avg`=0xE0. A ninth sample of 0x20 → sum = 7·(−32)+32, so `o_avg`=0xE8.
- `i_clear` with `i_valid` and `i_data`=0x45 → `o_min`=`o_max`=`o_last`=0x45, `o_count`=1, `o_avg`=0x08.
- 300 valid samples → `o_count` holds at 255.
- With DISPLAY_TICKS=4, last sample 0x5A → `o_led` shows 6'b000101, then 6'b01xxxx after 4 cycles, then 6'b10xxxx, then 6'b11xxxx, then 6'b000101 again (6'b10xxxx returns to 6'b000101 when the macro is undefined).
- Assert `i_reset_n`=0 between clock edges while samples are streaming → outputs take their reset values within that cycle, and the FSM returns to SHOW_LAST.
